// File: rtl/data_memory32_arbiter_if.sv
// Requester-side bus of data_memory32_arbiter: two packed request lanes
// (lane 0 in the low bits) plus the shared registered response.
interface data_memory32_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [1:0]          req_valid;
  logic [1:0]          req_we;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          req_ready;
  logic [1:0]          resp_valid;
  logic                resp_err;
  logic [DATA_W-1:0]   resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/data_memory32_arbiter.sv
// Single-port owner of data_memory32: zero-fills every word after reset or on
// clear request, then grants one access per cycle round-robin with 1-cycle responses.
module data_memory32_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clear_req,
  data_memory32_arbiter_if.slave bus,
  output logic                   o_busy,
  output logic                   o_mem_write_enable,
  output logic [ADDR_W-1:0]      o_mem_addr,
  output logic [DATA_W-1:0]      o_mem_write_data,
  input  logic [DATA_W-1:0]      i_mem_read_data
);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_SERVE = 1'b1} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_rr_ptr;
  logic [1:0]        r_resp_valid;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;

  logic [1:0]        w_grant;
  logic              w_sel;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_oor;

  // Grant: single requester wins outright, contention goes to rr_ptr; none while filling or clearing.
  always_comb begin
    w_grant = 2'b00;
    if (r_state == ST_SERVE && !i_clear_req) begin
      case (bus.req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_rr_ptr ? 2'b10 : 2'b01;
        default: w_grant = 2'b00;
      endcase
    end else begin
      w_grant = 2'b00;
    end
  end

  // Mux the granted lane and range-check its address at full width.
  always_comb begin
    w_sel = w_grant[1];
    if (w_sel) begin
      w_sel_we    = bus.req_we[1];
      w_sel_addr  = bus.req_addr[2*ADDR_W-1:ADDR_W];
      w_sel_wdata = bus.req_wdata[2*DATA_W-1:DATA_W];
    end else begin
      w_sel_we    = bus.req_we[0];
      w_sel_addr  = bus.req_addr[ADDR_W-1:0];
      w_sel_wdata = bus.req_wdata[DATA_W-1:0];
    end
    w_oor = (w_sel_addr >= DEPTH_A);
  end

  // Memory port drive: fill writes in CLEAR, granted access in SERVE; out-of-range never writes.
  always_comb begin
    o_mem_write_enable = 1'b0;
    o_mem_addr         = '0;
    o_mem_write_data   = '0;
    case (r_state)
      ST_CLEAR: begin
        o_mem_write_enable = 1'b1;
        o_mem_addr         = r_clr_cnt;
        o_mem_write_data   = '0;
      end
      ST_SERVE: begin
        if (|w_grant) begin
          o_mem_write_enable = w_sel_we & ~w_oor;
          o_mem_addr         = w_sel_addr;
          o_mem_write_data   = w_sel_wdata;
        end else begin
          o_mem_write_enable = 1'b0;
          o_mem_addr         = '0;
          o_mem_write_data   = '0;
        end
      end
      default: begin
        o_mem_write_enable = 1'b0;
        o_mem_addr         = '0;
        o_mem_write_data   = '0;
      end
    endcase
  end

  // FSM, fill counter, round-robin pointer and registered response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_CLEAR;
      r_clr_cnt    <= '0;
      r_rr_ptr     <= 1'b0;
      r_resp_valid <= 2'b00;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= w_grant;
      r_resp_err   <= (|w_grant) & w_oor;
      r_resp_rdata <= ((|w_grant) && !w_sel_we && !w_oor) ? i_mem_read_data : '0;
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_cnt == LAST_A) begin
            r_clr_cnt <= '0;
            r_state   <= ST_SERVE;
          end else begin
            r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
          end
        end
        ST_SERVE: begin
          if (i_clear_req) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
          end else if (bus.req_valid == 2'b11) begin
            // Pointer moves only when both lanes competed for the grant.
            r_rr_ptr <= ~r_rr_ptr;
          end else begin
            r_rr_ptr <= r_rr_ptr;
          end
        end
        default: begin
          r_state   <= ST_CLEAR;
          r_clr_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready  = w_grant;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;
  assign o_busy         = (r_state == ST_CLEAR);
endmodule
